cmdout_stream_arbiter: RTL and testbench
========================================

# cmdout_stream_arbiter

Round-robin, packet-granular arbiter that merges the per-accelerator finish/command-out AXI-Stream ports into the single TID-tagged stream consumed by the command-out writer. A grant is held for a whole packet, from first beat to the TLAST beat, so the header, task id and parent task id words of one accelerator are never interleaved with another's. The output is registered, and the arbiter sustains one beat per cycle within a packet.

## Interface
- NUM_ACCS, 16, number of accelerator input ports (1..256; non-power-of-2 allowed)
- ACC_BITS, $clog2(NUM_ACCS) (1 when NUM_ACCS=1), width of TID

- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- acc_TDATA  in  NUM_ACCS*64  port i data at bits [64*i+63:64*i]
- acc_TVALID  in  NUM_ACCS  per-port valid
- acc_TLAST  in  NUM_ACCS  per-port end of packet
- acc_TREADY  out  NUM_ACCS  per-port ready; only the granted bit can be 1
- m_TDATA  out  64  merged data
- m_TID  out  ACC_BITS  index of the source port
- m_TLAST  out  1  end of packet
- m_TVALID  out  1  merged valid
- m_TREADY  in  1  downstream ready
- busy  out  1  1 when state is PASS or m_TVALID=1

## Operation
- State machine: IDLE, PASS.
- **IDLE**
  - Search acc_TVALID starting at rr_ptr, ascending with wrap (index NUM_ACCS-1 is followed by 0).
  - On the first hit: grant <= hit index, go to PASS.
  - No hit: stay in IDLE.
  - All acc_TREADY = 0 in IDLE.
- **PASS**
  - acc_TREADY[grant] = (!m_TVALID | m_TREADY). All other bits are 0. This is combinational from m_TVALID and m_TREADY only, never from acc_TVALID.
  - An input beat is accepted when acc_TVALID[grant] & acc_TREADY[grant].
  - On accept: m_TDATA <= acc_TDATA[grant], m_TID <= grant, m_TLAST <= acc_TLAST[grant], m_TVALID <= 1.
  - On accept with TLAST=1: go to IDLE, and rr_ptr <= (grant == NUM_ACCS-1) ? 0 : grant+1.
- **Output register**
  - If m_TVALID & m_TREADY and no new beat is loaded that cycle: m_TVALID <= 0.
  - While m_TVALID & !m_TREADY, all m_* outputs hold stable.
- **Packet length**: not checked. A grant persists until TLAST, and a port that never asserts TLAST holds the grant forever. By protocol, command-out packets are 3 beats.
- **Non-granted ports**: a port with TVALID=1 and no grant sees TREADY=0 and must keep its data stable (AXI rule). The arbiter takes no action.
- **rr_ptr width**: ACC_BITS. It is compared and wrapped explicitly, never by natural overflow.

## Timing
- **Reset values**: state=IDLE, rr_ptr=0, grant=0, acc_TREADY=0, m_TVALID=0, m_TDATA=0, m_TID=0, m_TLAST=0, busy=0.
- **Reset mid-packet**: the partial packet and the output register are discarded immediately. The upstream port is not rewound. Reset is a system-level event.
- **Arbitration latency**: a request seen in cycle N gives grant/PASS in N+1 and the earliest input accept in N+1.
- **Output latency**: a beat accepted in cycle N appears on m_* in N+1.
- **Throughput**
  - 1 beat/cycle within a packet while m_TREADY=1.
  - 1 idle input cycle between packets (the IDLE arbitration cycle).
  - A 3-beat packet therefore occupies 4 cycles at the input.
- **Simultaneous requests**: the lowest index at or after rr_ptr wins. With all ports requesting continuously, each port is granted once per NUM_ACCS packets.
- **Backpressure**: m_TREADY=0 with m_TVALID=1 forces acc_TREADY[grant]=0 that cycle, so no beat is lost or duplicated.
- **TLAST under backpressure**: TLAST on a beat held by backpressure does not end the grant. Only an accepted TLAST beat ends it.

## Test plan
- **Single packet**: NUM_ACCS=16. Port 3 sends 0x80, 0x1234, 0x0 (TLAST on beat 3) with m_TREADY=1 -> m_* shows the 3 beats on consecutive cycles, m_TID=3, TLAST on the third; rr_ptr=4 afterwards; acc_TREADY[other]=0 throughout.
- **Fairness**: ports 0, 5 and 15 each request 2 packets simultaneously, rr_ptr=0 -> grant order 0, 5, 15, 0, 5, 15; no interleaving within a packet; m_TID matches each packet.
- **Backpressure**: m_TREADY toggles 1,0,0,1,0,1 during a packet from port 7 -> m_TDATA/m_TID/m_TLAST stable while m_TVALID & !m_TREADY; exactly 3 beats delivered in order; no duplicates.
- **Wrap**: NUM_ACCS=5, rr_ptr=4, ports 4 and 1 requesting -> port 4 is served first, then rr_ptr=0, then port 1 is served; rr_ptr never takes value 5–7.
- **Late requester**: port 2 asserts TVALID mid-packet of port 9 -> acc_TREADY[2] stays 0 until port 9's TLAST beat is accepted; port 2 is granted 1 cycle later.
- **Reset mid-packet**: rst=1 asynchronously after beat 2 of port 6 -> all outputs reach their reset values without waiting for a clk edge. After release, a new packet from port 6 starts at beat 1 with m_TID=6.

Source files
------------

// File: rtl/cmdout_stream_arbiter.sv
// Round-robin, packet-granular merge of accelerator cmd-out streams into one TID-tagged stream.
// Output registered (1 cycle); the granted TREADY follows output-register space only, never input valid.
module cmdout_stream_arbiter #(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ACCS*64-1:0] acc_TDATA,
  input  logic [NUM_ACCS-1:0]    acc_TVALID,
  input  logic [NUM_ACCS-1:0]    acc_TLAST,
  output logic [NUM_ACCS-1:0]    acc_TREADY,
  output logic [63:0]            m_TDATA,
  output logic [ACC_BITS-1:0]    m_TID,
  output logic                   m_TLAST,
  output logic                   m_TVALID,
  input  logic                   m_TREADY,
  output logic                   busy
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t              state, state_nxt;
  logic [ACC_BITS-1:0] rr_ptr, grant, hit_idx;
  logic [NUM_ACCS-1:0] req_rot;
  logic                hit_vld;
  logic [63:0]         sel_data;
  logic                sel_vld, sel_last;
  logic                out_free, accept;
  int                  pos;

  assign out_free = !m_TVALID || m_TREADY;
  assign accept   = (state == PASS) && sel_vld && out_free;
  assign busy     = (state == PASS) || m_TVALID;

  // Requests rotated so bit 0 is rr_ptr; the lowest set bit wins, then is mapped back with wrap.
  always_comb begin
    req_rot = NUM_ACCS'({acc_TVALID, acc_TVALID} >> rr_ptr);
    hit_vld = 1'b0;
    hit_idx = '0;
    pos     = 0;
    for (int k = NUM_ACCS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        hit_vld = 1'b1;
        pos     = int'(rr_ptr) + k;
        if (pos >= NUM_ACCS) pos = pos - NUM_ACCS;
        hit_idx = pos[ACC_BITS-1:0];
      end
    end
  end

  always_comb begin
    sel_data   = '0;
    sel_vld    = 1'b0;
    sel_last   = 1'b0;
    acc_TREADY = '0;
    for (int i = 0; i < NUM_ACCS; i++) begin
      if (int'(grant) == i) begin
        sel_data      = acc_TDATA[64*i +: 64];
        sel_vld       = acc_TVALID[i];
        sel_last      = acc_TLAST[i];
        acc_TREADY[i] = (state == PASS) && out_free;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit_vld) state_nxt = PASS;
      PASS:    if (accept && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      m_TDATA  <= '0;
      m_TID    <= '0;
      m_TLAST  <= 1'b0;
      m_TVALID <= 1'b0;
    end else begin
      if (state == IDLE && hit_vld) grant <= hit_idx;
      if (accept) begin
        m_TDATA  <= sel_data;
        m_TID    <= grant;
        m_TLAST  <= sel_last;
        m_TVALID <= 1'b1;
        // Explicit wrap keeps rr_ptr inside 0..NUM_ACCS-1 for non-power-of-2 port counts.
        if (sel_last) begin
          if (int'(grant) == NUM_ACCS - 1) rr_ptr <= '0;
          else                             rr_ptr <= grant + ACC_BITS'(1);
        end
      end else if (m_TVALID && m_TREADY) begin
        m_TVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmdout_stream_arbiter.sv
// Directed bench for cmdout_stream_arbiter: 16-port instance for packet/fairness/backpressure/reset,
// 5-port instance for pointer wrap. Inputs change at posedge+1, outputs sampled at negedge.
module tb_cmdout_stream_arbiter;
  localparam int N  = 16;
  localparam int NB = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*64-1:0] acc_TDATA;
  logic [N-1:0]    acc_TVALID, acc_TLAST, acc_TREADY;
  logic [63:0]     m_TDATA;
  logic [3:0]      m_TID;
  logic            m_TLAST, m_TVALID, m_TREADY, busy;

  logic [NB*64-1:0] b_TDATA;
  logic [NB-1:0]    b_TVALID, b_TLAST, b_TREADY;
  logic [63:0]      b_m_TDATA;
  logic [2:0]       b_m_TID;
  logic             b_m_TLAST, b_m_TVALID, b_m_TREADY, b_busy;

  always #5 clk = ~clk;

  cmdout_stream_arbiter #(.NUM_ACCS(N)) dut (
    .clk(clk), .rst(rst), .acc_TDATA(acc_TDATA), .acc_TVALID(acc_TVALID), .acc_TLAST(acc_TLAST),
    .acc_TREADY(acc_TREADY), .m_TDATA(m_TDATA), .m_TID(m_TID), .m_TLAST(m_TLAST),
    .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .busy(busy));

  cmdout_stream_arbiter #(.NUM_ACCS(NB)) dut_b (
    .clk(clk), .rst(rst), .acc_TDATA(b_TDATA), .acc_TVALID(b_TVALID), .acc_TLAST(b_TLAST),
    .acc_TREADY(b_TREADY), .m_TDATA(b_m_TDATA), .m_TID(b_m_TID), .m_TLAST(b_m_TLAST),
    .m_TVALID(b_m_TVALID), .m_TREADY(b_m_TREADY), .busy(b_busy));

  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] src_dat [N][8];
  logic        src_lst [N][8];
  int          src_cnt [N];
  int          src_rd  [N];
  logic [N-1:0]  fire   = '0;
  logic [NB-1:0] b_fire = '0;
  logic [N-1:0]  rdy_mask = 16'h0008;

  int          out_tid[$];
  logic [63:0] out_dat[$];
  logic        out_lst[$];
  int          out_cyc[$];
  int          b_out[$];

  int rdy_bad = 0, stab_bad = 0, stall_cnt = 0, wait2 = 0, b_ptr_bad = 0;
  int t9_last = -1, t2_rdy = -1, b_ptr_at4 = -1;
  logic        hold_vld = 1'b0, hold_lst = 1'b0;
  logic [63:0] hold_dat = '0;
  logic [3:0]  hold_tid = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int p, input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
    logic [63:0] d [3];
    d = '{d0, d1, d2};
    for (int b = 0; b < 3; b++) begin
      src_dat[p][src_cnt[p]] = d[b];
      src_lst[p][src_cnt[p]] = (b == 2);
      src_cnt[p]++;
    end
  endtask

  task automatic clear_bench();
    for (int p = 0; p < N; p++) begin
      src_cnt[p] = 0;
      src_rd[p]  = 0;
    end
    fire = '0; b_fire = '0; b_TVALID = '0;
    out_tid.delete(); out_dat.delete(); out_lst.delete(); out_cyc.delete(); b_out.delete();
    hold_vld = 1'b0; rdy_bad = 0; stab_bad = 0; stall_cnt = 0; wait2 = 0; b_ptr_bad = 0;
    t9_last = -1; t2_rdy = -1; b_ptr_at4 = -1;
    m_TREADY = 1'b1;
  endtask

  task automatic reset_all();
    @(negedge clk); #2;
    rst = 1'b1;
    clear_bench();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int k = 0;
    while (out_dat.size() < n && k < 100) begin
      @(negedge clk); #1; k++;
    end
    repeat (3) @(negedge clk);
    #1 chk(tag, out_dat.size(), n);
  endtask

  task automatic wait_b(input int n, input string tag);
    int k = 0;
    while (b_out.size() < n && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk(tag, b_out.size(), n);
  endtask

  // Upstream sources: pop on the handshake seen at the preceding negedge, then present the next beat.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int p = 0; p < N; p++) begin
      if (fire[p]) src_rd[p]++;
      if (src_rd[p] < src_cnt[p]) begin
        acc_TVALID[p]         = 1'b1;
        acc_TDATA[64*p +: 64] = src_dat[p][src_rd[p]];
        acc_TLAST[p]          = src_lst[p][src_rd[p]];
      end else begin
        acc_TVALID[p]         = 1'b0;
        acc_TDATA[64*p +: 64] = '0;
        acc_TLAST[p]          = 1'b0;
      end
    end
    b_TVALID = b_TVALID & ~b_fire;
  end

  always @(negedge clk) begin
    if (rst) begin
      fire = '0; b_fire = '0; hold_vld = 1'b0;
    end else begin
      fire   = acc_TVALID & acc_TREADY;
      b_fire = b_TVALID & b_TREADY;
      if (m_TVALID && m_TREADY) begin
        out_tid.push_back(int'(m_TID)); out_dat.push_back(m_TDATA);
        out_lst.push_back(m_TLAST);     out_cyc.push_back(cyc);
      end
      if ((acc_TREADY & ~rdy_mask) != '0) rdy_bad++;
      if (hold_vld && !(m_TVALID && m_TDATA == hold_dat && m_TID == hold_tid && m_TLAST == hold_lst))
        stab_bad++;
      hold_vld = m_TVALID && !m_TREADY;
      hold_dat = m_TDATA; hold_tid = m_TID; hold_lst = m_TLAST;
      if (m_TVALID && !m_TREADY) stall_cnt++;
      if (acc_TVALID[2] && !acc_TREADY[2] && t9_last < 0) wait2++;
      if (fire[9] && acc_TLAST[9]) t9_last = cyc;
      if (acc_TREADY[2] && t2_rdy < 0) t2_rdy = cyc;
      if (b_m_TVALID && b_m_TREADY) begin
        b_out.push_back(int'(b_m_TID));
        if (b_m_TID == 3'd4) b_ptr_at4 = int'(dut_b.rr_ptr);
      end
      if (int'(dut_b.rr_ptr) >= NB) b_ptr_bad++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_d;
    int          pts [3];
    int          late_tid [6];
    pts      = '{0, 5, 15};
    late_tid = '{9, 9, 9, 2, 2, 2};
    rst = 1'b1; m_TREADY = 1'b1; b_m_TREADY = 1'b1;
    acc_TDATA = '0; acc_TVALID = '0; acc_TLAST = '0;
    b_TVALID = '0; b_TLAST = '1;
    for (int i = 0; i < NB; i++) b_TDATA[64*i +: 64] = 64'hB0 + 64'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mvalid", m_TVALID, 0);  chk("rst_tid", m_TID, 0);
    chk("rst_tdata", m_TDATA, 0);    chk("rst_tlast", m_TLAST, 0);
    chk("rst_tready", acc_TREADY, 0); chk("rst_busy", busy, 0);
    chk("rst_rrptr", dut.rr_ptr, 0);
    #2 rst = 1'b0;

    // Single 3-beat packet from port 3
    @(negedge clk); #2;
    push_pkt(3, 64'h80, 64'h1234, 64'h0);
    wait_out(3, "single_cnt");
    chk("single_d0", out_dat[0], 64'h80);
    chk("single_d1", out_dat[1], 64'h1234);
    chk("single_d2", out_dat[2], 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk("single_tid", out_tid[k], 3);
      chk("single_last", out_lst[k], (k == 2));
    end
    chk("single_gap01", out_cyc[1] - out_cyc[0], 1);
    chk("single_gap12", out_cyc[2] - out_cyc[1], 1);
    chk("single_rrptr", dut.rr_ptr, 4);
    chk("single_rdy_other", rdy_bad, 0);
    chk("single_busy_end", busy, 0);

    // Fairness: ports 0, 5, 15 with two packets each
    reset_all();
    rdy_mask = 16'h8021;
    @(negedge clk); #2;
    for (int pk = 0; pk < 2; pk++)
      for (int j = 0; j < 3; j++)
        push_pkt(pts[j], 64'(pts[j] * 256 + pk * 16), 64'(pts[j] * 256 + pk * 16 + 1),
                 64'(pts[j] * 256 + pk * 16 + 2));
    wait_out(18, "fair_cnt");
    for (int j = 0; j < 6; j++)
      for (int b = 0; b < 3; b++) begin
        exp_d = 64'(pts[j % 3] * 256 + (j / 3) * 16 + b);
        chk("fair_tid", out_tid[j*3+b], pts[j % 3]);
        chk("fair_data", out_dat[j*3+b], exp_d);
        chk("fair_last", out_lst[j*3+b], (b == 2));
      end
    chk("fair_rdy_other", rdy_bad, 0);

    // Backpressure on a packet from port 7
    reset_all();
    rdy_mask = 16'h0080;
    @(negedge clk); #2;
    push_pkt(7, 64'hA1, 64'hA2, 64'hA3);
    begin
      logic [5:0] pat;
      pat = 6'b101001;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        m_TREADY = pat[k];
      end
    end
    m_TREADY = 1'b1;
    wait_out(3, "bp_cnt");
    chk("bp_d0", out_dat[0], 64'hA1);
    chk("bp_d1", out_dat[1], 64'hA2);
    chk("bp_d2", out_dat[2], 64'hA3);
    chk("bp_tid", out_tid[2], 7);
    chk("bp_last", out_lst[2], 1);
    chk("bp_stalls", stall_cnt, 2);
    chk("bp_stable", stab_bad, 0);
    chk("bp_rdy_other", rdy_bad, 0);

    // Late requester: port 2 arrives during port 9's packet
    reset_all();
    rdy_mask = 16'h0204;
    @(negedge clk); #2;
    push_pkt(9, 64'h91, 64'h92, 64'h93);
    repeat (2) @(negedge clk);
    #2 push_pkt(2, 64'h21, 64'h22, 64'h23);
    wait_out(6, "late_cnt");
    for (int k = 0; k < 6; k++) chk("late_tid", out_tid[k], late_tid[k]);
    chk("late_d3", out_dat[3], 64'h21);
    chk("late_wait", wait2, 2);
    chk("late_grant_gap", t2_rdy - t9_last, 2);
    chk("late_rdy_other", rdy_bad, 0);

    // Asynchronous reset in the middle of a packet from port 6
    reset_all();
    rdy_mask = 16'h0040;
    @(negedge clk); #2;
    push_pkt(6, 64'h61, 64'h62, 64'h63);
    begin
      int k = 0;
      while (src_rd[6] < 2 && k < 50) begin
        @(negedge clk); #1; k++;
      end
    end
    #1;
    chk("mr_pre_data", m_TDATA, 64'h62);
    chk("mr_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_mvalid", m_TVALID, 0); chk("mr_tdata", m_TDATA, 0);
    chk("mr_tid", m_TID, 0);       chk("mr_tlast", m_TLAST, 0);
    chk("mr_tready", acc_TREADY, 0); chk("mr_busy", busy, 0);
    clear_bench();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk); #2;
    push_pkt(6, 64'h71, 64'h72, 64'h73);
    wait_out(3, "mr_cnt");
    chk("mr_new_d0", out_dat[0], 64'h71);
    chk("mr_new_tid", out_tid[0], 6);
    chk("mr_new_d2", out_dat[2], 64'h73);
    chk("mr_new_last", out_lst[2], 1);

    // Pointer wrap on the 5-port instance
    reset_all();
    @(negedge clk); #2;
    b_TVALID[3] = 1'b1;
    wait_b(1, "wrap_first_cnt");
    chk("wrap_first_tid", b_out[0], 3);
    chk("wrap_rrptr4", dut_b.rr_ptr, 4);
    @(negedge clk); #2;
    b_TVALID[4] = 1'b1;
    b_TVALID[1] = 1'b1;
    wait_b(3, "wrap_cnt");
    chk("wrap_tid_a", b_out[1], 4);
    chk("wrap_tid_b", b_out[2], 1);
    chk("wrap_ptr_after4", b_ptr_at4, 0);
    chk("wrap_ptr_range", b_ptr_bad, 0);
    chk("wrap_rrptr_end", dut_b.rr_ptr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
